alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
Shares the single combinational `alu` datapath (A, B, ALUFun, Sign -> Z) between two requesters, for example the main pipeline and a multi-cycle helper unit.
- Accepts operations through valid/ready handshakes and arbitrates round-robin.
- Latches operands, drives the ALU for a configurable number of settle cycles, captures Z, and returns it on a held response channel.
- Rejects ALUFun codes the ALU does not implement.

Parameters:
EXEC_CYCLES, 1, cycles the ALU inputs are held stable before Z is captured (1..15; sizes the settle counter).
WIDTH, 32, operand/result width; must match the ALU.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous active-low reset.
req0_valid  input  1  requester 0 has an operation.
req0_ready  output  1  requester 0 operation accepted this cycle.
req0_a  input  WIDTH  operand A (shift amount in [4:0] for shifts).
req0_b  input  WIDTH  operand B.
req0_fun  input  6  ALUFun code.
req0_sign  input  1  signed compare select.
rsp0_valid  output  1  result for requester 0 available.
rsp0_ready  input  1  requester 0 consumes result.
rsp0_z  output  WIDTH  result.
rsp0_err  output  1  unsupported ALUFun; rsp0_z = 0.
req1_* / rsp1_*  same set as above for requester 1.
alu_a  output  WIDTH  to ALU A.
alu_b  output  WIDTH  to ALU B.
alu_fun  output  6  to ALU ALUFun.
alu_sign  output  1  to ALU Sign.
alu_z  input  WIDTH  from ALU Z.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, prio=0, all rsp*_valid/err=0, rsp*_z=0.
  - alu_a/b/fun/sign=0, settle counter=0.
- States: IDLE -> EXEC -> RESP -> IDLE.
- IDLE, grant:
  - If exactly one reqN_valid=1, grant N.
  - If both are valid, grant prio.
  - reqN_ready=1 only in IDLE for the granted N; it is combinational from the valids.
  - Requester valid must not depend on ready.
  - Transfer when valid && ready.
- IDLE, on transfer:
  - Latch a/b/fun/sign into alu_* registers and record owner=N.
  - Set prio to the other requester.
  - If fun is legal: go to EXEC with counter=0.
  - If fun is illegal: go to RESP with err=1, z=0.
- Legal codes (16): 000000, 000001, 011000, 011110, 010110, 010001, 011010, 100000, 100001, 100011, 110011, 110001, 110101, 111101, 111001, 111111.
- EXEC:
  - alu_* held stable; counter increments each cycle.
  - When counter==EXEC_CYCLES-1, capture alu_z into rsp_owner_z, set rsp_owner_valid=1, err=0, go to RESP.
- RESP:
  - rsp_owner_valid/z/err held stable until rsp_owner_ready=1.
  - In that cycle: clear valid, go to IDLE.
  - The other rsp channel stays 0.
  - req*_ready=0 in EXEC and RESP.
- Latency from accept to rsp_valid: EXEC_CYCLES+1 cycles for legal ops, 1 cycle for illegal ops.
- Minimum spacing between accepts: EXEC_CYCLES+2 cycles when the response is consumed immediately.
- alu_* outputs retain the last operation's values outside EXEC; the ALU is not re-driven while idle.
- Width rule: Z is passed through unmodified; compare ops yield 0/1 in bit 0.
- Mid-operation reset aborts immediately: no response is issued, and prio returns to 0.

Test Plan:
- Single op, ADD: req0 A=10, B=3, fun=000000, EXEC_CYCLES=1 -> req0_ready in accept cycle; rsp0_valid exactly 2 cycles later with rsp0_z=13, err=0.
- Shift sequence on req1: SLL A=3, B=10 -> z=80; then SRA A=3, B=0xFFFFFFFF -> z=0xFFFFFFFF; then SRL A=3, B=10 -> z=1.
- Contention: both valid every cycle, req0 SUB 10-3, req1 AND 10&3.
  - Grants alternate 0,1,0,1 starting with 0.
  - rsp0_z=7, rsp1_z=2.
  - Never two grants within EXEC_CYCLES+2 cycles.
- Backpressure: hold rsp0_ready=0 for 5 cycles after rsp0_valid -> rsp0_z/valid stable, req*_ready=0 throughout; accept resumes the cycle after rsp0_ready=1.
- Illegal code: fun=000111 -> rsp_valid 1 cycle after accept, err=1, z=0; the following LT A=0, B=1 returns z=1, err=0.
- Reset mid-EXEC with EXEC_CYCLES=4: assert reset at counter=2 -> no rsp*_valid; all outputs 0 immediately; the next request from req0 wins when both are valid.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between two requesters.
// Each accepted operation is held on the ALU for EXEC_CYCLES cycles, and its result is returned on a held response channel.
module alu_arbiter #(
  parameter int EXEC_CYCLES = 1,
  parameter int WIDTH       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [5:0]       req0_fun,
  input  logic             req0_sign,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_z,
  output logic             rsp0_err,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [5:0]       req1_fun,
  input  logic             req1_sign,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_z,
  output logic             rsp1_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [5:0]       alu_fun,
  output logic             alu_sign,
  input  logic [WIDTH-1:0] alu_z
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam int CW = 4;
  localparam logic [CW-1:0] LAST = CW'(EXEC_CYCLES - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             owner;
  logic             prio;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_err;
  logic [WIDTH-1:0] rsp_z [2];

  logic             gnt0, gnt1, accept, owner_ready;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [5:0]       sel_fun;
  logic             sel_sign;

  function automatic logic fun_legal(input logic [5:0] f);
    case (f)
      6'b000000, 6'b000001, 6'b011000, 6'b011110,
      6'b010110, 6'b010001, 6'b011010, 6'b100000,
      6'b100001, 6'b100011, 6'b110011, 6'b110001,
      6'b110101, 6'b111101, 6'b111001, 6'b111111: fun_legal = 1'b1;
      default:                                     fun_legal = 1'b0;
    endcase
  endfunction

  // Grant depends only on the valids and prio, so ready is combinational
  // but never feeds back into a requester's valid.
  always_comb begin
    gnt0 = req0_valid && (!req1_valid || !prio);
    gnt1 = req1_valid && (!req0_valid ||  prio);
  end

  assign req0_ready  = (state == IDLE) && gnt0;
  assign req1_ready  = (state == IDLE) && gnt1;
  assign accept      = req0_ready || req1_ready;
  assign owner_ready = owner ? rsp1_ready : rsp0_ready;

  assign sel_a    = gnt1 ? req1_a    : req0_a;
  assign sel_b    = gnt1 ? req1_b    : req0_b;
  assign sel_fun  = gnt1 ? req1_fun  : req0_fun;
  assign sel_sign = gnt1 ? req1_sign : req0_sign;

  assign rsp0_valid = rsp_valid[0];
  assign rsp1_valid = rsp_valid[1];
  assign rsp0_err   = rsp_err[0];
  assign rsp1_err   = rsp_err[1];
  assign rsp0_z     = rsp_z[0];
  assign rsp1_z     = rsp_z[1];

  // NOTE: every register here, including the two-entry response array, has a
  // reset value, and all of them are updated with non-blocking assignments so
  // that the order of the statements does not change the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      owner     <= 1'b0;
      prio      <= 1'b0;
      rsp_valid <= '0;
      rsp_err   <= '0;
      rsp_z[0]  <= '0;
      rsp_z[1]  <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_fun   <= '0;
      alu_sign  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            alu_a    <= sel_a;
            alu_b    <= sel_b;
            alu_fun  <= sel_fun;
            alu_sign <= sel_sign;
            owner    <= gnt1;
            prio     <= !gnt1;
            cnt      <= '0;
            if (fun_legal(sel_fun)) begin
              state <= EXEC;
            end else begin
              rsp_valid[gnt1] <= 1'b1;
              rsp_err[gnt1]   <= 1'b1;
              rsp_z[gnt1]     <= '0;
              state           <= RESP;
            end
          end
        end
        EXEC: begin
          if (cnt == LAST) begin
            rsp_valid[owner] <= 1'b1;
            rsp_err[owner]   <= 1'b0;
            rsp_z[owner]     <= alu_z;
            state            <= RESP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RESP: begin
          // Clear the whole channel on consume so that idle response ports read zero.
          if (owner_ready) begin
            rsp_valid[owner] <= 1'b0;
            rsp_err[owner]   <= 1'b0;
            rsp_z[owner]     <= '0;
            state            <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU model.
// Instance d1 uses EXEC_CYCLES=1, and instance d4 uses EXEC_CYCLES=4; both share the stimulus.
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic reset;
  logic        req0_valid, req1_valid, req0_sign, req1_sign, rsp0_ready, rsp1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [5:0]  req0_fun, req1_fun;

  logic        d1_req0_ready, d1_req1_ready, d1_rsp0_valid, d1_rsp1_valid;
  logic        d1_rsp0_err, d1_rsp1_err, d1_alu_sign;
  logic [31:0] d1_rsp0_z, d1_rsp1_z, d1_alu_a, d1_alu_b, d1_alu_z;
  logic [5:0]  d1_alu_fun;
  logic        d4_req0_ready, d4_req1_ready, d4_rsp0_valid, d4_rsp1_valid;
  logic        d4_rsp0_err, d4_rsp1_err, d4_alu_sign;
  logic [31:0] d4_rsp0_z, d4_rsp1_z, d4_alu_a, d4_alu_b, d4_alu_z;
  logic [5:0]  d4_alu_fun;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Behavioural ALU; any other code yields a marker value so a leaked Z stands out.
  function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [5:0] f, input logic s);
    case (f)
      6'b000000: alu_model = a + b;
      6'b000001: alu_model = a - b;
      6'b011000: alu_model = a & b;
      6'b011110: alu_model = a | b;
      6'b010110: alu_model = a ^ b;
      6'b010001: alu_model = ~(a | b);
      6'b011010: alu_model = a;
      6'b100000: alu_model = b << a[4:0];
      6'b100001: alu_model = b >> a[4:0];
      6'b100011: alu_model = $unsigned($signed(b) >>> a[4:0]);
      6'b110011: alu_model = {31'd0, a == b};
      6'b110001: alu_model = {31'd0, a != b};
      6'b110101: alu_model = {31'd0, s ? ($signed(a) < $signed(b)) : (a < b)};
      default:   alu_model = 32'hDEAD_BEEF;
    endcase
  endfunction

  assign d1_alu_z = alu_model(d1_alu_a, d1_alu_b, d1_alu_fun, d1_alu_sign);
  assign d4_alu_z = alu_model(d4_alu_a, d4_alu_b, d4_alu_fun, d4_alu_sign);

  alu_arbiter #(.EXEC_CYCLES(1), .WIDTH(32)) d1 (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(d1_req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_fun(req0_fun), .req0_sign(req0_sign),
    .rsp0_valid(d1_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_z(d1_rsp0_z), .rsp0_err(d1_rsp0_err),
    .req1_valid(req1_valid), .req1_ready(d1_req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_fun(req1_fun), .req1_sign(req1_sign),
    .rsp1_valid(d1_rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_z(d1_rsp1_z), .rsp1_err(d1_rsp1_err),
    .alu_a(d1_alu_a), .alu_b(d1_alu_b), .alu_fun(d1_alu_fun), .alu_sign(d1_alu_sign), .alu_z(d1_alu_z)
  );

  alu_arbiter #(.EXEC_CYCLES(4), .WIDTH(32)) d4 (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(d4_req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_fun(req0_fun), .req0_sign(req0_sign),
    .rsp0_valid(d4_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_z(d4_rsp0_z), .rsp0_err(d4_rsp0_err),
    .req1_valid(req1_valid), .req1_ready(d4_req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_fun(req1_fun), .req1_sign(req1_sign),
    .rsp1_valid(d4_rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_z(d4_rsp1_z), .rsp1_err(d4_rsp1_err),
    .alu_a(d4_alu_a), .alu_b(d4_alu_b), .alu_fun(d4_alu_fun), .alu_sign(d4_alu_sign), .alu_z(d4_alu_z)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    checks++;
    if ({d1_rsp0_valid, d1_rsp1_valid, d1_rsp0_err, d1_rsp1_err} !== 4'b0) begin
      errors++; $display("FAIL reset_rsp_flags got %b want 0000",
                         {d1_rsp0_valid, d1_rsp1_valid, d1_rsp0_err, d1_rsp1_err});
    end
    checks++;
    if ({d1_rsp0_z, d1_rsp1_z, d1_alu_a, d1_alu_b} !== 128'd0) begin
      errors++; $display("FAIL reset_data got %h %h %h %h want 0", d1_rsp0_z, d1_rsp1_z, d1_alu_a, d1_alu_b);
    end
    checks++;
    if ({d1_alu_fun, d1_alu_sign} !== 7'd0) begin
      errors++; $display("FAIL reset_alu_fun got %b want 0", {d1_alu_fun, d1_alu_sign});
    end
    tick();
    reset = 1'b1;
    tick();
  endtask

  // One transaction on d1: checks ready, latency, result, error flag, and the idle other channel.
  task automatic do_op(input int n, input logic [31:0] a, input logic [31:0] b, input logic [5:0] f,
                       input logic s, input logic [31:0] exp_z, input logic exp_err, input int exp_lat,
                       input string name);
    int lat;
    if (n == 0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_fun = f; req0_sign = s;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_fun = f; req1_sign = s;
    end
    #1;
    checks++;
    if ((n == 0 ? d1_req0_ready : d1_req1_ready) !== 1'b1) begin
      errors++; $display("FAIL %s_ready got 0 want 1", name);
    end
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    lat = 1;
    while ((n == 0 ? d1_rsp0_valid : d1_rsp1_valid) !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    checks++;
    if (lat != exp_lat) begin
      errors++; $display("FAIL %s_latency got %0d want %0d", name, lat, exp_lat);
    end
    checks++;
    if ((n == 0 ? d1_rsp0_z : d1_rsp1_z) !== exp_z) begin
      errors++; $display("FAIL %s_z got %h want %h", name, (n == 0 ? d1_rsp0_z : d1_rsp1_z), exp_z);
    end
    checks++;
    if ((n == 0 ? d1_rsp0_err : d1_rsp1_err) !== exp_err) begin
      errors++; $display("FAIL %s_err got %b want %b", name, (n == 0 ? d1_rsp0_err : d1_rsp1_err), exp_err);
    end
    checks++;
    if ((n == 0 ? d1_rsp1_valid : d1_rsp0_valid) !== 1'b0) begin
      errors++; $display("FAIL %s_other_valid got 1 want 0", name);
    end
    if (n == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
    tick();
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    checks++;
    if ((n == 0 ? d1_rsp0_valid : d1_rsp1_valid) !== 1'b0) begin
      errors++; $display("FAIL %s_consume got valid=1 want 0", name);
    end
  endtask

  task automatic test_single_add();
    do_op(0, 32'd10, 32'd3, 6'b000000, 1'b0, 32'd13, 1'b0, 2, "add");
  endtask

  task automatic test_shifts();
    do_op(1, 32'd3, 32'd10, 6'b100000, 1'b0, 32'd80, 1'b0, 2, "sll");
    do_op(1, 32'd3, 32'hFFFF_FFFF, 6'b100011, 1'b0, 32'hFFFF_FFFF, 1'b0, 2, "sra");
    do_op(1, 32'd3, 32'd10, 6'b100001, 1'b0, 32'd1, 1'b0, 2, "srl");
  endtask

  task automatic test_illegal();
    do_op(0, 32'd5, 32'd9, 6'b000111, 1'b0, 32'd0, 1'b1, 1, "illegal");
    do_op(0, 32'd0, 32'd1, 6'b110101, 1'b1, 32'd1, 1'b0, 2, "lt");
  endtask

  task automatic test_contention();
    int ngrant = 0, last = -10, nrsp0 = 0, nrsp1 = 0;
    pulse_reset();
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd3; req0_fun = 6'b000001; req0_sign = 1'b0;
    req1_valid = 1'b1; req1_a = 32'd10; req1_b = 32'd3; req1_fun = 6'b011000; req1_sign = 1'b0;
    for (int c = 0; c < 16; c++) begin
      #1;
      if (d1_rsp0_valid) begin
        nrsp0++;
        checks++;
        if (d1_rsp0_z !== 32'd7 || d1_rsp0_err !== 1'b0) begin
          errors++; $display("FAIL cont_rsp0 got z=%0d err=%b want z=7 err=0", d1_rsp0_z, d1_rsp0_err);
        end
      end
      if (d1_rsp1_valid) begin
        nrsp1++;
        checks++;
        if (d1_rsp1_z !== 32'd2 || d1_rsp1_err !== 1'b0) begin
          errors++; $display("FAIL cont_rsp1 got z=%0d err=%b want z=2 err=0", d1_rsp1_z, d1_rsp1_err);
        end
      end
      if (d1_req0_ready || d1_req1_ready) begin
        checks++;
        if ({d1_req1_ready, d1_req0_ready} !== ((ngrant % 2 == 0) ? 2'b01 : 2'b10)) begin
          errors++; $display("FAIL cont_grant%0d got %b want %b", ngrant, {d1_req1_ready, d1_req0_ready},
                             (ngrant % 2 == 0) ? 2'b01 : 2'b10);
        end
        checks++;
        if (c - last < 3) begin
          errors++; $display("FAIL cont_spacing got %0d want >=3", c - last);
        end
        last = c;
        ngrant++;
      end
      if (c == 13) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      tick();
    end
    checks++;
    if (ngrant != 5 || nrsp0 != 3 || nrsp1 != 2) begin
      errors++; $display("FAIL cont_counts got g=%0d r0=%0d r1=%0d want 5 3 2", ngrant, nrsp0, nrsp1);
    end
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_fun = 6'b000000; req0_sign = 1'b0;
    #1;
    tick();
    req0_valid = 1'b0;
    tick();
    req0_valid = 1'b1;
    req1_valid = 1'b1; req1_a = 32'd6; req1_b = 32'd3; req1_fun = 6'b011000; req1_sign = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (d1_rsp0_valid !== 1'b1 || d1_rsp0_z !== 32'd3) begin
        errors++; $display("FAIL bp_hold%0d got valid=%b z=%0d want 1 3", i, d1_rsp0_valid, d1_rsp0_z);
      end
      checks++;
      if ({d1_req0_ready, d1_req1_ready} !== 2'b00) begin
        errors++; $display("FAIL bp_ready%0d got %b want 00", i, {d1_req0_ready, d1_req1_ready});
      end
      tick();
    end
    rsp0_ready = 1'b1;
    tick();
    rsp0_ready = 1'b0;
    req0_valid = 1'b0;
    #1;
    checks++;
    if ({d1_rsp0_valid, d1_req1_ready} !== 2'b01) begin
      errors++; $display("FAIL bp_resume got valid=%b req1_ready=%b want 0 1", d1_rsp0_valid, d1_req1_ready);
    end
    tick();
    req1_valid = 1'b0;
    tick();
    checks++;
    if (d1_rsp1_valid !== 1'b1 || d1_rsp1_z !== 32'd2) begin
      errors++; $display("FAIL bp_rsp1 got valid=%b z=%0d want 1 2", d1_rsp1_valid, d1_rsp1_z);
    end
    rsp1_ready = 1'b1;
    tick();
    rsp1_ready = 1'b0;
  endtask

  task automatic test_exec4_latency();
    int lat;
    pulse_reset();
    req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd6; req0_fun = 6'b000000; req0_sign = 1'b0;
    #1;
    tick();
    req0_valid = 1'b0;
    lat = 1;
    while (d4_rsp0_valid !== 1'b1 && lat < 30) begin
      tick();
      lat++;
    end
    checks++;
    if (lat != 5 || d4_rsp0_z !== 32'd11) begin
      errors++; $display("FAIL exec4_latency got lat=%0d z=%0d want 5 11", lat, d4_rsp0_z);
    end
    rsp0_ready = 1'b1;
    tick();
    rsp0_ready = 1'b0;
  endtask

  task automatic test_reset_mid_exec();
    logic seen = 1'b0;
    pulse_reset();
    req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd6; req0_fun = 6'b000000; req0_sign = 1'b0;
    #1;
    tick();
    req0_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (d4_alu_a !== 32'd5) begin
      errors++; $display("FAIL rst_mid_pre got alu_a=%0d want 5", d4_alu_a);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({d4_rsp0_valid, d4_rsp1_valid, d4_alu_a, d4_alu_b, d4_alu_fun, d4_rsp0_z} !== 104'd0) begin
      errors++; $display("FAIL rst_mid_outputs got v=%b a=%0d b=%0d f=%b z=%0d want 0",
                         {d4_rsp0_valid, d4_rsp1_valid}, d4_alu_a, d4_alu_b, d4_alu_fun, d4_rsp0_z);
    end
    tick();
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (d4_rsp0_valid || d4_rsp1_valid) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL rst_mid_no_rsp got 1 want 0");
    end
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    checks++;
    if ({d4_req0_ready, d4_req1_ready} !== 2'b10) begin
      errors++; $display("FAIL rst_mid_prio got %b want 10", {d4_req0_ready, d4_req1_ready});
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    pulse_reset();
  endtask

  initial begin
    reset = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_fun = '0; req0_sign = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_fun = '0; req1_sign = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    #2;
    test_reset();
    test_single_add();
    test_shifts();
    test_illegal();
    test_contention();
    test_backpressure();
    test_exec4_latency();
    test_reset_mid_exec();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
